// File: rtl/decode_stage.sv
// Decode stage: field extraction, operand fetch with writeback forwarding,
// register scoreboard for RAW/WAW interlock, and a 1-deep output register.
module decode_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_imm,
  output logic [4:0]  out_dest,
  output logic        out_wen,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_funct,
  output logic        out_illegal
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm16  = instr[15:0];

  assign read_reg_1 = rs;
  assign read_reg_2 = rt;

  logic is_r, is_alui, is_logi, is_lw, is_st, is_j;
  assign is_r    = opcode == 6'h00;
  assign is_alui = opcode == 6'h08;
  assign is_logi = opcode == 6'h0C || opcode == 6'h0D;
  assign is_lw   = opcode == 6'h23;
  assign is_st   = opcode == 6'h2B || opcode == 6'h04;
  assign is_j    = opcode == 6'h02;

  logic       use_rs, use_rt, has_dest, illegal;
  logic [4:0] dest_f;

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    has_dest = 1'b0;
    illegal  = 1'b0;
    dest_f   = rt;
    unique case (1'b1)
      is_r: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        has_dest = 1'b1;
        dest_f   = rd;
      end
      is_alui, is_logi, is_lw: begin
        use_rs   = 1'b1;
        has_dest = 1'b1;
      end
      is_st: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      is_j: ;
      default: illegal = 1'b1;
    endcase
  end

  logic [31:0] imm;
  assign imm = is_j    ? {6'b0, instr[25:0]} :
               is_logi ? {16'b0, imm16} :
                         {{16{imm16[15]}}, imm16};

  logic       wen;
  logic [4:0] dest;
  assign wen  = has_dest && dest_f != 5'd0;
  assign dest = wen ? dest_f : 5'd0;

  // A writeback in flight this cycle beats the stale register-file read
  logic        wb_rs, wb_rt, wb_dst;
  logic [31:0] op1, op2;
  assign wb_rs  = reg_write && write_reg == rs;
  assign wb_rt  = reg_write && write_reg == rt;
  assign wb_dst = reg_write && write_reg == dest_f;
  assign op1 = rs == 5'd0 ? 32'd0 : wb_rs ? write_data : rd1;
  assign op2 = rt == 5'd0 ? 32'd0 : wb_rt ? write_data : rd2;

  logic [NREG-1:0] pending, pend_nxt;
  logic            hazard, accept;

  assign hazard = (use_rs && pending[rs] && !wb_rs) ||
                  (use_rt && pending[rt] && !wb_rt) ||
                  (has_dest && pending[dest_f] && !wb_dst);

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Clear first so a same-cycle set on the same register wins
  always_comb begin
    pend_nxt = pending;
    if (reg_write)
      pend_nxt[write_reg] = 1'b0;
    if (accept && wen)
      pend_nxt[dest] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_dest    <= '0;
      out_wen     <= 1'b0;
      out_opcode  <= '0;
      out_funct   <= '0;
      out_illegal <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (accept) begin
        out_valid   <= 1'b1;
        out_op1     <= op1;
        out_op2     <= op2;
        out_imm     <= imm;
        out_dest    <= dest;
        out_wen     <= wen;
        out_opcode  <= opcode;
        out_funct   <= instr[5:0];
        out_illegal <= illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage against a behavioural
// model of the decode table, scoreboard and handshake.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic [4:0]  read_reg_1, read_reg_2;
  logic [31:0] rd1, rd2;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_imm;
  logic [4:0]  out_dest;
  logic        out_wen, out_illegal;
  logic [5:0]  out_opcode, out_funct;

  decode_stage #(.NREG(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .rd1(rd1), .rd2(rd2),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_dest(out_dest), .out_wen(out_wen),
    .out_opcode(out_opcode), .out_funct(out_funct),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  assign rd1 = regs[read_reg_1];
  assign rd2 = regs[read_reg_2];

  typedef struct packed {
    logic [31:0] op1, op2, imm;
    logic [4:0]  dest;
    logic        wen;
    logic [5:0]  opc, fn;
    logic        ill, urs, urt;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mp;
  logic        mov;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] s,
      input logic rw, input logic [4:0] wr, input logic [31:0] wd);
    if (s == 0) return 32'd0;
    if (rw && wr == s) return wd;
    return regs[s];
  endfunction

  // Reference decode: which sources are read, destination, immediate
  task automatic dec(input logic [31:0] ins, input logic rw,
                     input logic [4:0] wr, input logic [31:0] wd,
                     output exp_t e, output logic hd,
                     output logic [4:0] df);
    logic [5:0]  op;
    logic [15:0] i16;
    op = ins[31:26];
    i16 = ins[15:0];
    e = '0;
    hd = 1'b0;
    df = ins[20:16];
    e.imm = {{16{i16[15]}}, i16};
    case (op)
      6'h00: begin e.urs = 1; e.urt = 1; hd = 1; df = ins[15:11]; end
      6'h08, 6'h23: begin e.urs = 1; hd = 1; end
      6'h0C, 6'h0D: begin e.urs = 1; hd = 1; e.imm = {16'd0, i16}; end
      6'h2B, 6'h04: begin e.urs = 1; e.urt = 1; end
      6'h02: e.imm = {6'd0, ins[25:0]};
      default: e.ill = 1;
    endcase
    e.wen  = hd && df != 0;
    e.dest = e.wen ? df : 5'd0;
    e.opc  = op;
    e.fn   = ins[5:0];
    e.op1  = opnd(ins[25:21], rw, wr, wd);
    e.op2  = opnd(ins[20:16], rw, wr, wd);
  endtask

  function automatic logic busy(input logic [4:0] r, input logic rw,
                                input logic [4:0] wr);
    return mp[r] && !(rw && wr == r);
  endfunction

  task automatic step(input logic iv, input logic [31:0] ins,
                      input logic ordy, input logic rw,
                      input logic [4:0] wr, input logic [31:0] wd,
                      output logic rdy);
    exp_t       e;
    logic       hd, haz, erdy, acc;
    logic [4:0] df;
    @(negedge clk);
    in_valid = iv; instr = ins; out_ready = ordy;
    reg_write = rw; write_reg = wr; write_data = wd;
    #1;
    dec(ins, rw, wr, wd, e, hd, df);
    haz = (e.urs && busy(ins[25:21], rw, wr)) ||
          (e.urt && busy(ins[20:16], rw, wr)) ||
          (hd && busy(df, rw, wr));
    erdy = (!mov || ordy) && !haz;
    rdy = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, erdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mov});
    chk("read_regs", {22'd0, read_reg_1, read_reg_2},
        {22'd0, ins[25:21], ins[20:16]});
    chk("pending", dut.pending, mp);
    acc = iv && erdy;
    if (acc) q.push_back(e);
    @(posedge clk);
    #1;
    if (rw) begin mp[wr] = 1'b0; regs[wr] = wd; end
    if (acc && e.wen) mp[e.dest] = 1'b1;
    mp[0] = 1'b0;
    if (acc) mov = 1'b1;
    else if (ordy) mov = 1'b0;
  endtask

  // Monitor: every completed transfer must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          if (e.urs) chk("op1", out_op1, e.op1);
          if (e.urt) chk("op2", out_op2, e.op2);
          chk("imm", out_imm, e.imm);
          chk("dest_wen", {26'd0, out_dest, out_wen},
              {26'd0, e.dest, e.wen});
          chk("opc_fn_ill", {19'd0, out_opcode, out_funct, out_illegal},
              {19'd0, e.opc, e.fn, e.ill});
        end
      end
    end
  end

  function automatic logic [31:0] rnd_instr();
    logic [5:0]  op;
    logic [31:0] w;
    case ($urandom_range(0, 9))
      0, 1: op = 6'h00;
      2: op = 6'h08;
      3: op = 6'h0C;
      4: op = 6'h0D;
      5: op = 6'h23;
      6: op = 6'h2B;
      7: op = 6'h04;
      8: op = 6'h02;
      default: op = 6'($urandom_range(0, 63));
    endcase
    w = $urandom;
    w[31:26] = op;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  logic        r;
  logic [31:0] snap [4];

  initial begin
    rst = 1'b0;
    in_valid = 0; instr = 0; out_ready = 0;
    reg_write = 0; write_reg = 0; write_data = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 0;
    mp = 0;
    mov = 0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_op1 | out_op2 | out_imm |
        {21'd0, out_dest, out_wen, out_opcode} | {25'd0, out_funct, out_illegal},
        32'd0);
    @(negedge clk);
    rst = 1'b1;

    // addi r1,r0,-1
    step(1, 32'h2001FFFF, 1, 0, 0, 0, r);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_op1", out_op1, 32'd0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_dest", {27'd0, out_dest}, 32'd1);
    chk("addi_wen", {31'd0, out_wen}, 32'd1);
    chk("addi_pend1", {31'd0, dut.pending[1]}, 32'd1);

    // add r3,r1,r2 stalls on r1, then issues with forwarded writeback
    step(1, 32'h00221820, 1, 0, 0, 0, r);
    chk("raw_stall", {31'd0, r}, 32'd0);
    step(1, 32'h00221820, 1, 1, 1, 32'hB19B00B5, r);
    chk("raw_accept", {31'd0, r}, 32'd1);
    chk("raw_fwd", out_op1, 32'hB19B00B5);

    // illegal opcode 0x3F
    step(1, 32'hFC221820, 1, 0, 0, 0, r);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_wen", {31'd0, out_wen}, 32'd0);
    chk("ill_pend", dut.pending, 32'h8);

    // same-cycle set and clear on r5
    step(1, 32'h20050001, 1, 1, 5, 32'h55, r);
    chk("setwin_pend5", {31'd0, dut.pending[5]}, 32'd1);
    step(0, 0, 1, 1, 3, 32'h33, r);
    step(0, 0, 1, 1, 5, 32'h77, r);

    // backpressure: hold three cycles then stream
    step(1, 32'h20060042, 1, 0, 0, 0, r);
    snap[0] = out_imm; snap[1] = {27'd0, out_dest};
    snap[2] = out_op1; snap[3] = {26'd0, out_opcode};
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h34071234, 0, 0, 0, 0, r);
      chk("bp_ready", {31'd0, r}, 32'd0);
      chk("bp_hold", {out_imm ^ snap[0]} | {out_dest ^ snap[1][4:0]} |
          (out_op1 ^ snap[2]) | {out_opcode ^ snap[3][5:0]}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, {6'h0D, 5'd0, 5'(8 + i), 16'(i)}, 1, 0, 0, 0, r);
      chk("stream_ready", {31'd0, r}, 32'd1);
    end

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 8, rnd_instr(),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
           wr, $urandom, r);
    end

    for (int i = 1; i < 32; i++) step(0, 0, 1, 1, 5'(i), $urandom, r);

    // reset during a stall with r1 pending
    step(1, 32'h2001FFFF, 0, 0, 0, 0, r);
    step(0, 0, 0, 0, 0, 0, r);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pend", dut.pending, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_data", out_op1 | out_imm | {27'd0, out_dest}, 32'd0);
    q.delete();
    mp = 0;
    mov = 0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 1, 1, 32'h1234, r);
    chk("post_rst_pend", dut.pending, 32'd0);
    step(1, 32'h2002000A, 1, 0, 0, 0, r);
    step(0, 0, 1, 0, 0, 0, r);
    step(0, 0, 1, 0, 0, 0, r);
    chk("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
